// File: rtl/chs_pkg.sv
// Shared types and default parameters for the chs_pwm_ctrl cool/heat controller.
package chs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOL  = 2'd1,
        HEAT  = 2'd2,
        DRAIN = 2'd3
    } chs_state_t;

    localparam logic MODE_COOL = 1'b1;
    localparam logic MODE_HEAT = 1'b0;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_PWR_W      = 4;
    localparam int DEF_STEP_SHIFT = 2;
    localparam int DEF_HYST       = 4;

endpackage

// File: rtl/chs_pwm_gen.sv
// PWM generator: free-running period counter, boundary flag, duty register
// and registered PWM output; duty only changes on the period boundary.
module chs_pwm_gen #(
    parameter int PWR_W = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [PWR_W-1:0] level,
    input  logic             load,
    output logic             boundary,
    output logic [PWR_W-1:0] duty,
    output logic             pwm_data
);

    logic [PWR_W-1:0] cnt;

    assign boundary = (cnt == '1);

    // Counter wraps naturally; duty is loaded on the same edge the counter returns to 0.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt      <= '0;
            duty     <= '0;
            pwm_data <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;
            pwm_data <= (cnt < duty);
            if (load) begin
                duty <= level;
            end
        end
    end

endmodule

// File: rtl/chs_pwm_ctrl.sv
// Cool/heat controller with threshold window, hysteresis and PWM power drive.
// Optional macro CHS_RAMP_EN: power steps one level per PWM period toward target.
module chs_pwm_ctrl
    import chs_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PWR_W      = DEF_PWR_W,
    parameter int STEP_SHIFT = DEF_STEP_SHIFT,
    parameter int HYST       = DEF_HYST
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [DATA_W-1:0] temp,
    input  logic [DATA_W-1:0] cfg_low,
    input  logic [DATA_W-1:0] cfg_high,
    input  logic              cfg_load,
    output logic              cfg_err,
    output logic              chs_mode,
    output logic              chs_active,
    output logic [PWR_W-1:0]  chs_power,
    output logic              pwm_data
);

    localparam logic [DATA_W:0]   HYST_X = (DATA_W+1)'(HYST);
    localparam logic [DATA_W:0]   TMAX_X = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W-1:0] PMAX_D = DATA_W'((1 << PWR_W) - 1);

    logic [DATA_W-1:0] temp_q;
    logic [DATA_W-1:0] low_q;
    logic [DATA_W-1:0] high_q;
    chs_state_t        state;
    chs_state_t        state_next;
    logic              mode_next;
    logic [DATA_W:0]   t_x;
    logic [DATA_W:0]   cool_exit;
    logic [DATA_W:0]   heat_sum;
    logic [DATA_W:0]   heat_exit;
    logic [DATA_W-1:0] excess;
    logic [DATA_W-1:0] scaled;
    logic [PWR_W-1:0]  target;
    logic [PWR_W-1:0]  level_next;
    logic              boundary;

    // An inverted window is rejected outright and remembered until reset.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            low_q   <= '0;
            high_q  <= '1;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            if (cfg_low < cfg_high) begin
                low_q  <= cfg_low;
                high_q <= cfg_high;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            temp_q <= '0;
        end else begin
            temp_q <= temp;
        end
    end

    always_comb begin
        t_x       = {1'b0, temp_q};
        cool_exit = ({1'b0, high_q} >= HYST_X) ? ({1'b0, high_q} - HYST_X) : '0;
        heat_sum  = {1'b0, low_q} + HYST_X;
        heat_exit = (heat_sum > TMAX_X) ? TMAX_X : heat_sum;
    end

    // Active modes always request at least one level so the drive never stalls at 0.
    always_comb begin
        excess = '0;
        target = '0;
        case (state)
            COOL:    if (temp_q > high_q) excess = temp_q - high_q;
            HEAT:    if (low_q > temp_q)  excess = low_q - temp_q;
            default: excess = '0;
        endcase
        scaled = excess >> STEP_SHIFT;
        if (state == COOL || state == HEAT) begin
            if (scaled > PMAX_D) begin
                target = '1;
            end else if (scaled == '0) begin
                target = PWR_W'(1);
            end else begin
                target = scaled[PWR_W-1:0];
            end
        end
    end

`ifdef CHS_RAMP_EN
    always_comb begin
        level_next = chs_power;
        if (chs_power < target) begin
            level_next = chs_power + 1'b1;
        end else if (chs_power > target) begin
            level_next = chs_power - 1'b1;
        end
    end
`else
    assign level_next = target;
`endif

    always_comb begin
        state_next = state;
        mode_next  = chs_mode;
        case (state)
            IDLE: begin
                if (temp_q > high_q) begin
                    state_next = COOL;
                    mode_next  = MODE_COOL;
                end else if (temp_q < low_q) begin
                    state_next = HEAT;
                    mode_next  = MODE_HEAT;
                end
            end
            COOL:    if (t_x <= cool_exit) state_next = DRAIN;
            HEAT:    if (t_x >= heat_exit) state_next = DRAIN;
            DRAIN:   if (boundary && level_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state    <= IDLE;
            chs_mode <= 1'b0;
        end else begin
            state    <= state_next;
            chs_mode <= mode_next;
        end
    end

    assign chs_active = (state != IDLE);

    chs_pwm_gen #(
        .PWR_W (PWR_W)
    ) u_pwm_gen (
        .clk      (clk),
        .arst     (arst),
        .level    (level_next),
        .load     (boundary),
        .boundary (boundary),
        .duty     (chs_power),
        .pwm_data (pwm_data)
    );

endmodule

// File: doc/chs_pwm_ctrl.md
Name: chs_pwm_ctrl

Overview:
Parametrised successor of the cool/heat system controller. It compares a sampled temperature against a loadable low/high threshold window with hysteresis and decides between cool, heat and idle. It produces a saturated power level and a glitch-free PWM drive whose duty changes only at PWM period boundaries. It sits between the sensor front-end and the fan/heater driver.

Parameters:
DATA_W, 8, width of temperature and threshold values
PWR_W, 4, width of power level; PWM period = 2^PWR_W clocks
STEP_SHIFT, 2, right shift applied to the threshold excess to form target power
HYST, 4, hysteresis in temperature LSBs for leaving an active mode

Ports:
clk  in  1  system clock
arst  in  1  reset, asynchronous, active-low
temp  in  DATA_W  measured temperature, unsigned
cfg_low  in  DATA_W  heat threshold
cfg_high  in  DATA_W  cool threshold
cfg_load  in  1  one-cycle strobe; latch cfg_low/cfg_high
cfg_err  out  1  sticky: an illegal config load was rejected
chs_mode  out  1  1 = cool, 0 = heat; holds last active direction
chs_active  out  1  cool or heat engaged, or draining
chs_power  out  PWR_W  applied power level
pwm_data  out  1  PWM drive, registered

Behaviour:
- Reset (arst low, asynchronous) clears all outputs to 0: cfg_err, chs_mode, chs_active, chs_power, pwm_data. Threshold registers reset to low = 0 and high = 2^DATA_W-1. FSM resets to IDLE; PWM counter and temp register reset to 0.
- Config: on cfg_load with cfg_low < cfg_high, thresholds update at that edge. With cfg_low >= cfg_high, the load is ignored, old values are kept and cfg_err is set. cfg_err clears only on reset.
- temp is registered every cycle. The FSM and target power use the registered value, so thresholds act one clock after temp changes.
- FSM states: IDLE, COOL, HEAT, DRAIN.
  - IDLE -> COOL when t > high.
  - IDLE -> HEAT when t < low.
  - COOL -> DRAIN when t <= high - HYST, computed in DATA_W+1 bits, floor 0.
  - HEAT -> DRAIN when t >= low + HYST, computed in DATA_W+1 bits, cap 2^DATA_W-1.
  - DRAIN -> IDLE at a period boundary with chs_power == 0.
  - DRAIN is never aborted; a new crossing is acted on only after IDLE is reached.
  - COOL <-> HEAT is never direct.
- chs_mode is set to 1 on entering COOL and 0 on entering HEAT, and is otherwise held. chs_active = (state != IDLE).
- Target power:
  - COOL: (t - high) >> STEP_SHIFT.
  - HEAT: (low - t) >> STEP_SHIFT.
  - Target saturates at 2^PWR_W-1 and has a minimum of 1 while COOL/HEAT.
  - IDLE and DRAIN: target 0.
- PWM: a free-running PWR_W-bit counter wraps from 2^PWR_W-1 to 0. The period boundary is the cycle where the counter == 2^PWR_W-1. chs_power updates only at the boundary.
- pwm_data is registered as (counter < chs_power). Power 0 gives constant low; the maximum gives 2^PWR_W-1 high clocks per 2^PWR_W.
- Simultaneous cfg_load and a threshold crossing: the FSM evaluates the old thresholds in that cycle.

Optional Feature:
Macro CHS_RAMP_EN.
- Defined: at each boundary chs_power moves one step toward target (+1 or -1, or unchanged if equal). DRAIN therefore ramps down one level per period.
- Undefined: chs_power loads the target directly at the boundary, so DRAIN lasts at most one period.

Decomposition:
- Shared package chs_pkg holds:
  - state enum (IDLE, COOL, HEAT, DRAIN)
  - mode constants MODE_COOL = 1, MODE_HEAT = 0
  - default parameter constants
- One sub-module, chs_pwm_gen (PWR_W), holds the counter, boundary flag, duty register and pwm_data. Power level and a load enable come from the FSM.

Test Plan (defaults; cfg_low = 0x40, cfg_high = 0x60):
- Reset mid-period with pwm_data high -> all outputs 0 immediately, without waiting for clk.
- temp = 0x78 -> COOL, chs_mode = 1, target 6. With ramp off, chs_power = 6 at the next boundary and pwm_data is high 6 of every 16 clocks; with ramp on, 1..6 over 6 periods.
- temp = 0xEE -> target saturates at 15; pwm_data is high 15 of 16 clocks.
- In COOL, temp 0x78 -> 0x5E (above high - HYST) -> stays COOL with target 1; then 0x5C -> DRAIN, chs_power reaches 0, IDLE, chs_active = 0.
- temp = 0x30 -> HEAT, chs_mode = 0, target 4; temp = 0x43 keeps HEAT; 0x44 -> DRAIN.
- cfg_load with low = 0x70, high = 0x60 -> rejected, cfg_err = 1, thresholds unchanged; a later legal load succeeds and cfg_err stays 1.
